// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 set-2 byte constants, prefix FSM states and helpers.
package ps2_pkg;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;
    localparam logic [7:0] PS2_BATERR = 8'hFC;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} ps2_pfx_t;

    // Bytes the keyboard sends as replies to host commands rather than keys.
    function automatic logic is_resp(input logic [7:0] b);
        return b inside {PS2_BAT, PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_BATERR, PS2_ERR0, PS2_ERR1};
    endfunction
endpackage

// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if: key-event bus towards the keyboard matrix.
//   key_strobe   one-cycle event pulse
//   key_code     scancode with prefixes stripped
//   key_pressed  1 = make, 0 = break
//   key_extended 1 = E0 prefix seen
//   frame_err    one-cycle pulse on parity/stop error
interface ps2_scancode_rx_if;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_pressed;
    logic       key_extended;
    logic       frame_err;
    modport master(output key_strobe, key_code, key_pressed, key_extended, frame_err);
    modport slave(input key_strobe, key_code, key_pressed, key_extended, frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: conditions raw PS/2 lines and deframes 11-bit serial bytes.
//   clk_sys, reset_n     system clock, async active-low reset
//   ps2_clk, ps2_data    raw asynchronous PS/2 lines
//   byte_valid           one-cycle pulse, byte_data holds a good byte
//   byte_data[7:0]       last received data byte
//   frame_err            one-cycle pulse on parity or stop-bit error
module ps2_rx_frame #(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [1:0]    clk_s, dat_s;
    logic          filt_clk, sample_en, settle, at_stop, stop_ok;
    logic [FW-1:0] filt_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    sr;
    logic          par;
    logic [TW-1:0] idle_cnt;
    // The synchronised clock must disagree with the filtered one for a full window before it is taken.
    assign settle     = (clk_s[1] != filt_clk) && (filt_cnt == FW'(FILTER_CYCLES - 1));
    assign at_stop    = sample_en && (bit_cnt == 4'd10);
    assign stop_ok    = dat_s[1] && ^{sr, par};
    assign byte_valid = at_stop && stop_ok;
    assign frame_err  = at_stop && !stop_ok;
    assign byte_data  = sr;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_s     <= 2'b11;
            dat_s     <= 2'b11;
            filt_clk  <= 1'b1;
            filt_cnt  <= '0;
            sample_en <= 1'b0;
        end else begin
            clk_s     <= {clk_s[0], ps2_clk};
            dat_s     <= {dat_s[0], ps2_data};
            sample_en <= settle && filt_clk;
            if (clk_s[1] == filt_clk) filt_cnt <= '0;
            else if (settle) begin
                filt_clk <= clk_s[1];
                filt_cnt <= '0;
            end else filt_cnt <= filt_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= '0;
            sr       <= '0;
            par      <= 1'b0;
            idle_cnt <= '0;
        end else if (sample_en) begin
            idle_cnt <= '0;
            if (bit_cnt == 4'd0) bit_cnt <= {3'b000, ~dat_s[1]};
            else if (bit_cnt == 4'd10) bit_cnt <= 4'd0;
            else begin
                if (bit_cnt == 4'd9) par <= dat_s[1];
                else sr <= {dat_s[1], sr[7:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else if (bit_cnt != 4'd0) begin
            // A stalled frame is dropped silently; prefix state upstream is untouched.
            if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt  <= 4'd0;
                idle_cnt <= '0;
            end else idle_cnt <= idle_cnt + 1'b1;
        end else idle_cnt <= '0;
    end
endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: decodes PS/2 set-2 scancode bytes into key events.
//   clk_sys, reset_n   system clock, async active-low reset
//   ps2_clk, ps2_data  raw PS/2 lines
//   key_if             key-event bus (strobe, code, pressed, extended, frame_err)
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      ps2_clk,
    input  logic                      ps2_data,
    ps2_scancode_rx_if.master         key_if
);
    logic       byte_valid, byte_err, emit;
    logic [7:0] byte_data;
    logic [2:0] skip, skip_nxt;
    ps2_pfx_t   state, state_nxt;
    ps2_rx_frame #(.FILTER_CYCLES(FILTER_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .frame_err(byte_err)
    );
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            skip  <= '0;
        end else begin
            state <= state_nxt;
            skip  <= skip_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip;
        emit      = 1'b0;
        if (byte_err) begin
            state_nxt = IDLE;
            skip_nxt  = '0;
        end else if (byte_valid) begin
            if (skip != 3'd0) skip_nxt = skip - 3'd1;
            else if (byte_data == PS2_PAUSE) begin
                // The remaining Pause bytes carry no usable make/break meaning.
                skip_nxt  = PAUSE_SKIP;
                state_nxt = IDLE;
            end else if (byte_data == PS2_EXT) state_nxt = (state == IDLE) ? EXT : state;
            else if (byte_data == PS2_BRK) state_nxt = (state == IDLE) ? BRK : (state == EXT) ? EXT_BRK : state;
            else if (!(state == IDLE && is_resp(byte_data))) begin
                emit      = 1'b1;
                state_nxt = IDLE;
            end
        end
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            key_if.key_strobe   <= 1'b0;
            key_if.key_code     <= '0;
            key_if.key_pressed  <= 1'b0;
            key_if.key_extended <= 1'b0;
            key_if.frame_err    <= 1'b0;
        end else begin
            key_if.key_strobe <= emit;
            key_if.frame_err  <= byte_err;
            if (emit) begin
                key_if.key_code     <= byte_data;
                key_if.key_pressed  <= !(state == BRK || state == EXT_BRK);
                key_if.key_extended <= (state == EXT || state == EXT_BRK);
            end
        end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: table-driven and scoreboard bench for ps2_scancode_rx.
module tb_ps2_scancode_rx;
    localparam int TO = 3000;
    typedef struct {
        logic [7:0] b;
        logic       bad;
        logic       ev;
        logic [7:0] code;
        logic       pr;
        logic       ex;
    } vec_t;
    typedef struct packed {
        logic [7:0] code;
        logic       pr;
        logic       ex;
    } ev_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    int   compared = 0;
    int   failed = 0;
    int   strobes = 0;
    int   errs = 0;
    ev_t  exp_q[$];
    vec_t vecs[$];

    ps2_scancode_rx_if key_if();
    ps2_scancode_rx #(.FILTER_CYCLES(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .key_if(key_if)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic bad, input logic ev,
                                input logic [7:0] code, input logic pr, input logic ex);
        vec_t v;
        v.b = b; v.bad = bad; v.ev = ev; v.code = code; v.pr = pr; v.ex = ex;
        return v;
    endfunction

    // Scoreboard: every strobe pops the oldest expected event.
    always @(negedge clk_sys) begin
        if (key_if.frame_err) errs++;
        if (key_if.key_strobe) begin
            strobes++;
            if (exp_q.size() == 0) chk("unexpected_strobe", int'(key_if.key_code), -1);
            else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("key_code", int'(key_if.key_code), int'(e.code));
                chk("key_pressed", int'(key_if.key_pressed), int'(e.pr));
                chk("key_extended", int'(key_if.key_extended), int'(e.ex));
            end
        end
    end

    task automatic send_bit(input logic d);
        ps2_data = d;
        repeat (20) @(posedge clk_sys);
        ps2_clk = 1'b0;
        repeat (40) @(posedge clk_sys);
        ps2_clk = 1'b1;
        repeat (20) @(posedge clk_sys);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic bad, input int n);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < n; i++) send_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    task automatic frame_check(input string name, input logic [7:0] b, input logic bad,
                               input logic ev, input logic [7:0] code, input logic pr, input logic ex);
        int s0, e0;
        s0 = strobes;
        e0 = errs;
        if (ev) exp_q.push_back({code, pr, ex});
        send_bits(b, bad, 11);
        repeat (30) @(posedge clk_sys);
        chk({name, "_strobes"}, strobes - s0, int'(ev));
        chk({name, "_errs"}, errs - e0, int'(bad));
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_strobe"}, int'(key_if.key_strobe), 0);
        chk({name, "_code"}, int'(key_if.key_code), 0);
        chk({name, "_pressed"}, int'(key_if.key_pressed), 0);
        chk({name, "_ext"}, int'(key_if.key_extended), 0);
        chk({name, "_err"}, int'(key_if.frame_err), 0);
    endtask

    initial begin
        vecs.push_back(mk(8'h1C, 0, 1, 8'h1C, 1, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h1C, 0, 1, 8'h1C, 0, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h75, 0, 1, 8'h75, 0, 1));
        vecs.push_back(mk(8'h1C, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h1B, 0, 1, 8'h1B, 1, 0));
        vecs.push_back(mk(8'hE1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h14, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h77, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'hE1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h14, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h77, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h16, 0, 1, 8'h16, 1, 0));
        vecs.push_back(mk(8'hAA, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h74, 0, 1, 8'h74, 1, 1));

        repeat (5) @(posedge clk_sys);
        #1 chk_zero_outputs("reset");
        reset_n = 1'b1;
        repeat (20) @(posedge clk_sys);

        for (int i = 0; i < vecs.size(); i++)
            frame_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].bad, vecs[i].ev,
                        vecs[i].code, vecs[i].pr, vecs[i].ex);

        // Stalled partial frame must be dropped by the timeout.
        send_bits(8'h33, 0, 5);
        repeat (TO + 10) @(posedge clk_sys);
        frame_check("timeout", 8'h29, 0, 1, 8'h29, 1, 0);

        // Short low glitches with data low must not look like a start bit.
        ps2_data = 1'b0;
        for (int g = 0; g < 3; g++) begin
            ps2_clk = 1'b0;
            repeat (4) @(posedge clk_sys);
            ps2_clk = 1'b1;
            repeat (20) @(posedge clk_sys);
        end
        ps2_data = 1'b1;
        frame_check("glitch", 8'h3C, 0, 1, 8'h3C, 1, 0);

        // Reset in the middle of an F0 frame.
        send_bits(8'hF0, 0, 6);
        reset_n = 1'b0;
        #1 chk_zero_outputs("midreset");
        repeat (5) @(posedge clk_sys);
        #1 chk_zero_outputs("inreset");
        reset_n = 1'b1;
        repeat (20) @(posedge clk_sys);
        frame_check("after_reset", 8'h45, 0, 1, 8'h45, 1, 0);

        chk("queue_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
